// File: rtl/fighter_anim_sprite.sv
// Animated, scaled, mirrorable fighter sprite: walks a multi-frame ROM strip and
// drives a 3-cycle pixel pipeline (DrawX/DrawY -> rom_address -> rom_q -> rgb).
module fighter_anim_sprite #(
  parameter int unsigned SPR_W      = 71,
  parameter int unsigned SPR_H      = 120,
  parameter int unsigned SCALE_SH   = 1,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned FRAME_HOLD = 6,
  parameter logic [3:0]  TRANS_IDX  = 4'hF,
  parameter int unsigned ADDR_W     = 16,
  localparam int unsigned FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         PosX,
  input  logic [9:0]         PosY,
  input  logic               facing_left,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic               anim_start,
  input  logic               anim_loop,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [3:0]         rom_q,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               sprite_on,
  output logic               anim_done,
  output logic [FRAME_W-1:0] frame_idx
);

  localparam int unsigned HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int unsigned G_W        = 11;
  localparam int unsigned BOX_W      = SPR_W << SCALE_SH;
  localparam int unsigned BOX_H      = SPR_H << SCALE_SH;
  localparam int unsigned FRAME_SIZE = SPR_W * SPR_H;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold, hold_n;
  logic [FRAME_W-1:0]  frame_n;
  logic                done_n;

  logic [9:0]          pos_x_q, pos_y_q;
  logic                facing_q;

  logic [G_W-1:0]      draw_x, draw_y, left, top, dx, dy, lx, ly, sx;
  logic                hit_c;
  logic [ADDR_W-1:0]   addr_c;
  logic                hit_d1, hit_d2;

  // Geometry is latched once per video frame so a mid-frame move cannot tear.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      facing_q <= 1'b0;
    end else if (frame_tick) begin
      pos_x_q  <= PosX;
      pos_y_q  <= PosY;
      facing_q <= facing_left;
    end
  end

  // S0: box test in 11 bits so a sprite near the right edge cannot wrap.
  always_comb begin
    draw_x = G_W'(DrawX);
    draw_y = G_W'(DrawY);
    left   = G_W'(pos_x_q);
    top    = G_W'(pos_y_q);
    dx     = draw_x - left;
    dy     = draw_y - top;
    lx     = dx >> SCALE_SH;
    ly     = dy >> SCALE_SH;
    sx     = facing_q ? (G_W'(SPR_W - 1) - lx) : lx;
    hit_c  = blank
          && (draw_x >= left) && (draw_x < left + G_W'(BOX_W))
          && (draw_y >= top)  && (draw_y < top  + G_W'(BOX_H));
    addr_c = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE)
           + ADDR_W'(ly) * ADDR_W'(SPR_W)
           + ADDR_W'(sx);
  end

  // S0..S2 pipeline registers: address, hit alignment and final colour key.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      hit_d1      <= 1'b0;
      hit_d2      <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      sprite_on   <= 1'b0;
    end else begin
      rom_address <= hit_c ? addr_c : '0;
      hit_d1      <= hit_c;
      hit_d2      <= hit_d1;
      if (hit_d2 && (rom_q != TRANS_IDX)) begin
        red       <= pal_red;
        green     <= pal_green;
        blue      <= pal_blue;
        sprite_on <= 1'b1;
      end else begin
        red       <= '0;
        green     <= '0;
        blue      <= '0;
        sprite_on <= 1'b0;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold      <= '0;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      frame_idx <= frame_n;
      anim_done <= done_n;
    end
  end

  // Animation sequencer; anim_start overrides a coincident frame_tick.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    frame_n = frame_idx;
    done_n  = 1'b0;
    if (anim_start) begin
      state_n = ST_PLAY;
      hold_n  = '0;
      frame_n = '0;
    end else begin
      case (state)
        ST_IDLE: frame_n = '0;
        ST_PLAY: begin
          if (frame_tick) begin
            if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
              hold_n = '0;
              if (frame_idx < FRAME_W'(NUM_FRAMES - 1)) begin
                frame_n = frame_idx + FRAME_W'(1);
              end else if (anim_loop) begin
                frame_n = '0;
              end else begin
                state_n = ST_DONE;
                done_n  = 1'b1;
              end
            end else begin
              hold_n = hold + HOLD_W'(1);
            end
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fighter_anim_sprite.sv
// Scoreboard bench for fighter_anim_sprite: stimulus queues expectations with a
// due cycle, a negedge monitor compares whatever falls due.
module tb_fighter_anim_sprite;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0, PosX = '0, PosY = '0;
  logic        facing_left = 1'b0, blank = 1'b0, frame_tick = 1'b0;
  logic        anim_start = 1'b0, anim_loop = 1'b0;
  logic [15:0] rom_address;
  logic [3:0]  rom_q = '0;
  logic [3:0]  pal_red, pal_green, pal_blue, red, green, blue;
  logic        sprite_on, anim_done;
  logic [1:0]  frame_idx;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    int          kind;
    int          tag;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  fighter_anim_sprite dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .PosX(PosX), .PosY(PosY), .facing_left(facing_left), .blank(blank),
    .frame_tick(frame_tick), .anim_start(anim_start), .anim_loop(anim_loop),
    .rom_address(rom_address), .rom_q(rom_q), .pal_red(pal_red),
    .pal_green(pal_green), .pal_blue(pal_blue), .red(red), .green(green),
    .blue(blue), .sprite_on(sprite_on), .anim_done(anim_done),
    .frame_idx(frame_idx)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  // Synchronous ROM returning the low address nibble; palette is a fixed offset.
  always @(posedge vga_clk) rom_q <= rom_address[3:0];
  assign pal_red   = rom_q + 4'd7;
  assign pal_green = rom_q + 4'd2;
  assign pal_blue  = rom_q + 4'd9;

  function automatic logic [15:0] pix(input logic hit, input logic [15:0] a);
    logic [3:0] q;
    q = a[3:0];
    if (hit && q != 4'hF) return {3'b0, 1'b1, q + 4'd7, q + 4'd2, q + 4'd9};
    return 16'h0;
  endfunction

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      0:       return rom_address;
      1:       return {3'b0, sprite_on, red, green, blue};
      default: return {13'b0, anim_done, frame_idx};
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      0:       return "rom_address";
      1:       return "pixel{on,r,g,b}";
      default: return "anim{done,frame}";
    endcase
  endfunction

  task automatic check(input string name, input int tag, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic expect_at(input int lat, input int kind, input int tag,
                           input logic [15:0] e);
    exp_t t;
    t.due  = cyc + lat;
    t.kind = kind;
    t.tag  = tag;
    t.exp  = e;
    sb.push_back(t);
  endtask

  always @(negedge vga_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check(kname(sb[i].kind), sb[i].tag, actual(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pixel(input int tag, input int x, input int y, input logic bl,
                       input logic hit, input logic [15:0] addr);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    expect_at(1, 0, tag, hit ? addr : 16'h0);
    expect_at(3, 1, tag, pix(hit, addr));
    tick();
  endtask

  task automatic idle(input int n);
    blank = 1'b0;
    repeat (n) tick();
  endtask

  // frame_tick (optionally with anim_start); anim_done must be a single-cycle pulse.
  task automatic anim_tick(input int tag, input logic start, input logic done_e,
                           input int f_e);
    frame_tick = 1'b1;
    anim_start = start;
    expect_at(1, 2, tag, {13'b0, done_e, 2'(f_e)});
    expect_at(2, 2, tag, {13'b0, 1'b0, 2'(f_e)});
    tick();
    frame_tick = 1'b0;
    anim_start = 1'b0;
    tick();
  endtask

  task automatic start_anim(input int tag);
    anim_start = 1'b1;
    expect_at(1, 2, tag, 16'h0);
    tick();
    anim_start = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_addr", 0, rom_address, 16'h0);
    check("rst_pix", 0, {3'b0, sprite_on, red, green, blue}, 16'h0);
    check("rst_anim", 0, {13'b0, anim_done, frame_idx}, 16'h0);
    reset = 1'b0;
    tick();

    // Stream pixel (0,0) in view, then assert reset mid-cycle.
    DrawX = '0; DrawY = '0; blank = 1'b1;
    repeat (4) tick();
    check("stream_on", 0, 16'(sprite_on), 16'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pix", 0, {3'b0, sprite_on, red, green, blue}, 16'h0);
    check("async_rst_addr", 0, rom_address, 16'h0);
    tick();
    reset = 1'b0;
    idle(2);

    pixel(1, 0, 0, 1'b1, 1'b1, 16'd0);
    idle(4);

    // Facing right at (100,50)
    PosX = 10'd100; PosY = 10'd50; facing_left = 1'b0;
    anim_tick(10, 1'b0, 1'b0, 0);
    pixel(11, 100, 50, 1'b1, 1'b1, 16'd0);
    pixel(12, 101, 50, 1'b1, 1'b1, 16'd0);
    pixel(13, 102, 50, 1'b1, 1'b1, 16'd1);
    pixel(14, 241, 50, 1'b1, 1'b1, 16'd70);
    pixel(15, 242, 50, 1'b1, 1'b0, 16'd0);
    pixel(16, 100, 52, 1'b1, 1'b1, 16'd71);
    pixel(17,  99, 50, 1'b1, 1'b0, 16'd0);
    pixel(18, 100, 49, 1'b1, 1'b0, 16'd0);
    pixel(19, 100, 50, 1'b0, 1'b0, 16'd0);
    pixel(20, 100, 289, 1'b1, 1'b1, 16'd8449);
    pixel(21, 100, 290, 1'b1, 1'b0, 16'd0);
    pixel(22, 130, 50, 1'b1, 1'b1, 16'd15);
    pixel(23, 106, 50, 1'b1, 1'b1, 16'd3);
    idle(4);

    // Facing left; mid-frame changes must not take effect
    facing_left = 1'b1;
    anim_tick(30, 1'b0, 1'b0, 0);
    pixel(31, 100, 50, 1'b1, 1'b1, 16'd70);
    pixel(32, 101, 50, 1'b1, 1'b1, 16'd70);
    pixel(33, 102, 50, 1'b1, 1'b1, 16'd69);
    pixel(34, 241, 50, 1'b1, 1'b1, 16'd0);
    pixel(35, 242, 50, 1'b1, 1'b0, 16'd0);
    pixel(36, 100, 52, 1'b1, 1'b1, 16'd141);
    facing_left = 1'b0; PosX = 10'd200;
    pixel(37, 100, 50, 1'b1, 1'b1, 16'd70);
    idle(4);

    // Box straddling the 10-bit wrap point
    PosX = 10'd1000;
    anim_tick(40, 1'b0, 1'b0, 0);
    pixel(41, 1010, 50, 1'b1, 1'b1, 16'd5);
    pixel(42, 5, 50, 1'b1, 1'b0, 16'd0);
    idle(4);

    // Non-looping animation
    PosX = 10'd100; PosY = 10'd50; facing_left = 1'b0; anim_loop = 1'b0;
    start_anim(100);
    for (int j = 1; j <= 24; j++) begin
      anim_tick(100 + j, 1'b0, j == 24, (j / 6 > 3) ? 3 : j / 6);
      if (j == 12) begin
        pixel(150, 100, 50, 1'b1, 1'b1, 16'd17040);
        blank = 1'b0;
      end
    end
    anim_tick(160, 1'b0, 1'b0, 3);

    // Looping animation, then anim_start coincident with a tick at hold=5
    anim_loop = 1'b1;
    start_anim(200);
    for (int j = 1; j <= 29; j++) anim_tick(200 + j, 1'b0, 1'b0, (j / 6) % 4);
    anim_tick(240, 1'b1, 1'b0, 0);
    for (int j = 1; j <= 5; j++) anim_tick(240 + j, 1'b0, 1'b0, 0);
    anim_tick(250, 1'b0, 1'b0, 1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout %s #%0d: never compared, expected %h",
               kname(sb[0].kind), sb[0].tag, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fighter_anim_sprite.md
Name: fighter_anim_sprite

Overview:
Parametrised, animated successor to the single-frame fighter sprite renderers. It is one instance per fighter, sitting between the VGA controller and the colour mapper.
- Walks a multi-frame sprite strip stored in an external synchronous ROM.
- Applies power-of-two integer scaling and optional horizontal mirroring (facing left/right), using no dividers.
- Keys out a transparent palette index.
- Sequences animation frames from a vsync-rate tick under a small FSM.

Parameters:
SPR_W, 71, sprite frame width in source pixels
SPR_H, 120, sprite frame height in source pixels
SCALE_SH, 1, on-screen scale = 2^SCALE_SH (box is SPR_W<<SCALE_SH by SPR_H<<SCALE_SH)
NUM_FRAMES, 4, frames stored back-to-back in ROM, frame k base = k*SPR_W*SPR_H
FRAME_HOLD, 6, frame_tick pulses each animation frame is displayed
TRANS_IDX, 4'hF, palette index treated as transparent
ADDR_W, 16, ROM address width; must satisfy NUM_FRAMES*SPR_W*SPR_H <= 2^ADDR_W

Ports:
vga_clk  in  1  pixel clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
PosX  in  10  sprite top-left X (screen)
PosY  in  10  sprite top-left Y (screen)
facing_left  in  1  1 = mirror horizontally
blank  in  1  1 = active video region
frame_tick  in  1  one-cycle pulse per video frame, issued during vertical blank
anim_start  in  1  one-cycle pulse: restart animation at frame 0
anim_loop  in  1  1 = wrap after last frame, 0 = stop on last frame
rom_address  out  ADDR_W  address to external ROM; rom_q valid one cycle later
rom_q  in  4  palette index from ROM
pal_red  in  4  combinational palette output for rom_q
pal_green  in  4  combinational palette output for rom_q
pal_blue  in  4  combinational palette output for rom_q
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
sprite_on  out  1  pixel belongs to opaque sprite
anim_done  out  1  one-cycle pulse when a non-looping animation finishes
frame_idx  out  log2(NUM_FRAMES) (min 1)  currently displayed frame

Behaviour:
Reset (asynchronous assert):
- red, green, blue, sprite_on, anim_done = 0; rom_address = 0; frame_idx = 0.
- Hold counter = 0; FSM = IDLE; latched position and facing = 0; all pipeline valid bits cleared.

Geometry latch:
- PosX, PosY and facing_left are sampled only in the cycle frame_tick=1. Mid-frame changes are ignored, so there is no tearing.
- frame_idx changes only on frame_tick or anim_start.

Pipeline (3 cycles, DrawX/DrawY at cycle N -> red/green/blue/sprite_on at cycle N+3):
- S0, combinational, registered at end of N: hit = blank and DrawX in [LX, LX + (SPR_W<<SCALE_SH)) and DrawY in [LY, LY + (SPR_H<<SCALE_SH)).
  - lx = (DrawX - LX) >> SCALE_SH; ly = (DrawY - LY) >> SCALE_SH.
  - sx = facing ? SPR_W-1-lx : lx.
  - rom_address = frame_idx*SPR_W*SPR_H + ly*SPR_W + sx. Constant multiplies only; no division.
  - On a miss, rom_address = 0 and hit = 0. Comparisons use 11-bit width so LX+width near 640 does not wrap.
- S1: ROM returns rom_q; hit delayed one stage.
- S2: if hit_d2 and rom_q != TRANS_IDX, then red/green/blue = pal_*, sprite_on = 1; otherwise all = 0.

Animation FSM (state changes on frame_tick/anim_start only):
- IDLE: frame_idx = 0. anim_start -> PLAY (hold = 0, frame_idx = 0).
- PLAY: on frame_tick, hold++. When hold == FRAME_HOLD-1: hold = 0, then:
  - if frame_idx < NUM_FRAMES-1: frame_idx++;
  - else if anim_loop: frame_idx = 0;
  - else -> DONE, frame_idx stays NUM_FRAMES-1, anim_done = 1 for exactly one cycle.
- DONE: holds last frame. anim_start -> PLAY with frame_idx = 0.
- anim_start and frame_tick in the same cycle: anim_start wins. frame_idx = 0, hold = 0, no advance that tick; geometry is still latched.
- anim_start while in PLAY: restart immediately (frame 0, hold 0).
- anim_loop is sampled at the wrap decision only.
- FRAME_HOLD = 1: advance on every tick.
- NUM_FRAMES = 1: a non-looping animation reaches DONE on the first FRAME_HOLD expiry.

Test Plan:
- Reset mid-pixel-stream with sprite in view -> all outputs 0 same cycle. After release with LX=LY=0 latched, pixel (0,0) at cycle N gives rom_address=0 at N+1 and sprite_on at N+3.
- Defaults, PosX=100, PosY=50 latched, facing_left=0: DrawX=100/101 -> rom_address 0; DrawX=102 -> 1; DrawX=241 -> 70; DrawX=242 -> miss, sprite_on=0; DrawY=52, DrawX=100 -> 71.
- Same position, facing_left=1: DrawX=100 -> rom_address 70; DrawX=241 -> 0. Toggling facing_left mid-frame has no effect until the next frame_tick.
- ROM returns 4'hF in-box -> sprite_on=0 and rgb=0. Returns 4'h3 with pal = 12'hA5C -> rgb A,5,C and sprite_on=1, exactly 3 cycles after DrawX.
- anim_loop=0, anim_start then 24 frame_ticks -> frame_idx steps 0,1,2,3 every 6 ticks; anim_done pulses once on tick 24; frame_idx stays 3. Frame 2 base address = 17040.
- anim_loop=1, 24 ticks -> frame_idx wraps to 0, no anim_done. anim_start coincident with a frame_tick at hold=5 -> frame_idx=0, hold=0.
